// File: rtl/misr_sig_analyzer_if.sv
// Sample stream from the pixel pipeline into the signature analyzer.
//   rdy  : sample valid strobe
//   data : CHANNELS samples, channel k at [k*DATA_W +: DATA_W]
// master drives the stream (pipeline / bench), slave observes it (analyzer).
interface misr_sig_analyzer_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 1
);
  logic                         rdy;
  logic [CHANNELS*DATA_W-1:0]   data;

  modport master (output rdy, output data);
  modport slave  (input  rdy, input  data);
endinterface

// File: rtl/misr_sig_analyzer.sv
// Multiple-input signature register: compacts count_i multi-channel sample
// sets into one signature and compares it against golden_i at completion.
//   clk_i, reset_i : clock, synchronous active-high reset
//   en_i           : level arm; rising edge starts a run, low aborts/releases
//   smp            : sample stream (rdy, data), slave side
//   count_i        : samples per run, latched at start
//   golden_i       : expected signature, sampled at completion
//   signature_o    : current signature register
//   sample_cnt_o   : sample sets absorbed in the current run
//   busy_o/done_o  : in RUN / in DONE
//   pass_o         : signature matched golden on entry to DONE
module misr_sig_analyzer #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       CHANNELS = 1,
  parameter int unsigned       SIG_W    = 16,
  parameter logic [SIG_W-1:0]  POLY     = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0]  SEED     = SIG_W'(16'h0000),
  parameter int unsigned       COUNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  misr_sig_analyzer_if.slave   smp,
  input  logic [COUNT_W-1:0]   count_i,
  input  logic [SIG_W-1:0]     golden_i,
  output logic [SIG_W-1:0]     signature_o,
  output logic [COUNT_W-1:0]   sample_cnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_n;
  logic               en_q;
  logic               blk_q;
  logic [SIG_W-1:0]   sig_q, sig_n, sig_step;
  logic [COUNT_W-1:0] cnt_q, cnt_n;
  logic [COUNT_W-1:0] lat_q, lat_n;
  logic               pass_q, pass_n;
  logic               start;

  // One MISR shift with feedback, absorbing a zero-extended word.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0]  s,
                                                 input logic [DATA_W-1:0] w);
    misr_step = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ SIG_W'(w);
  endfunction

  // Chain channel 0 .. CHANNELS-1 through the step in one cycle.
  always_comb begin
    sig_step = sig_q;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      sig_step = misr_step(sig_step, smp.data[k*DATA_W +: DATA_W]);
    end
  end

  // blk_q suppresses the edge detector when en_i was already high through
  // reset, so only a genuine low-to-high transition starts a run.
  assign start = en_i & ~en_q & ~blk_q;

  // Next-state and datapath update.
  always_comb begin
    state_n = state_q;
    sig_n   = sig_q;
    cnt_n   = cnt_q;
    lat_n   = lat_q;
    pass_n  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sig_n  = SEED;
          cnt_n  = '0;
          lat_n  = count_i;
          pass_n = 1'b0;
          if (count_i == '0) begin
            state_n = ST_DONE;
            pass_n  = (SEED == golden_i);
          end else begin
            state_n = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_n = ST_IDLE;
        end else if (cnt_q == lat_q) begin
          state_n = ST_DONE;
          pass_n  = (sig_q == golden_i);
        end else if (smp.rdy) begin
          sig_n = sig_step;
          cnt_n = cnt_q + COUNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!en_i) begin
          state_n = ST_IDLE;
          pass_n  = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      blk_q   <= en_i;
      sig_q   <= SEED;
      cnt_q   <= '0;
      lat_q   <= '0;
      pass_q  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_n;
      en_q    <= en_i;
      blk_q   <= blk_q & en_i;
      sig_q   <= sig_n;
      cnt_q   <= cnt_n;
      lat_q   <= lat_n;
      pass_q  <= pass_n;
      busy_o  <= (state_n == ST_RUN);
      done_o  <= (state_n == ST_DONE);
    end
  end

  assign signature_o  = sig_q;
  assign sample_cnt_o = cnt_q;
  assign pass_o       = pass_q;

endmodule
